// File: rtl/noc_local_injector_pkg.sv
// Shared types and constants for the NoC local injector.
//   - NoC geometry: VC count, coordinate widths
//   - Flit geometry: FLIT_W, payload width, MAX_LEN, length field width
//   - noc_flit_type_e : 2-bit flit type carried in flit_data[FLIT_W-1:FLIT_W-2]
//   - noc_head_t      : packed head-flit fields, zero-padded into the flit body
//   - noc_inj_state_e : injector FSM state, exported on the dbg_state port
package noc_local_injector_pkg;

  localparam int NOC_VC_CHANNEL = 4;
  localparam int NOC_ID_X_WIDTH = 4;
  localparam int NOC_ID_Y_WIDTH = 4;
  localparam int FLIT_W         = 64;
  localparam int PLD_W          = FLIT_W - 2;
  localparam int MAX_LEN        = 16;
  localparam int LEN_W          = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    FLIT_BODY      = 2'b00,
    FLIT_HEAD      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } noc_flit_type_e;

  // Field order is MSB first: dst_x is the highest field, len the lowest.
  typedef struct packed {
    logic [NOC_ID_X_WIDTH-1:0] dst_x;
    logic [NOC_ID_Y_WIDTH-1:0] dst_y;
    logic [NOC_ID_X_WIDTH-1:0] src_x;
    logic [NOC_ID_Y_WIDTH-1:0] src_y;
    logic [LEN_W-1:0]          len;
  } noc_head_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALLOC = 2'd1,
    ST_HEAD  = 2'd2,
    ST_BODY  = 2'd3
  } noc_inj_state_e;

  // Place the head fields in the low bits of the flit body, upper bits zero.
  function automatic logic [PLD_W-1:0] head_body(input noc_head_t h);
    logic [PLD_W-1:0] b;
    b = '0;
    b[$bits(noc_head_t)-1:0] = h;
    return b;
  endfunction

endpackage

// File: rtl/noc_local_injector_vc_rr_picker.sv
// Round-robin one-hot VC picker.
//   clk, rst     : clock, asynchronous active-high reset
//   req          : per-VC request (VC idle and may take a new packet)
//   advance      : commit the current pick; pointer moves past the granted VC
//   grant_idx    : index of the picked VC (valid when any_grant)
//   any_grant    : at least one VC requested
// The pointer holds the first index to try; it resets to 0 so the first
// packet after reset goes to the lowest idle VC.
module noc_local_injector_vc_rr_picker #(
  parameter int CHANNELS = 4,
  localparam int IDX_W = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                any_grant
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % CHANNELS);
      if (!any_grant && req[cand]) begin
        any_grant = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && any_grant) begin
      ptr_d = (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/noc_local_injector.sv
// NoC local injector: converts host packet requests (dest + payload stream)
// into HEAD/BODY/TAIL flits on one VC of the router local input port.
//   noc_clk, noc_rst : clock, asynchronous active-high reset
//   id_x, id_y       : own coordinates (source field of the head flit)
//   req_*            : packet request (valid/ready), dst and payload length
//   pld_*            : payload word stream (valid/ready)
//   flit_valid/data/ready : per-VC flit link toward the router
//   vc_ready         : per-VC idle indication, sampled only while allocating
//   busy             : packet in flight
//   dbg_state        : current FSM state
//   perf_pkt_cnt, perf_stall_cnt : present only with NOC_INJ_PERF_CNT_EN
//
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high. Once flit_valid is raised, flit_data and the VC stay fixed until
// flit_ready on that VC; in BODY the payload is passed straight through so
// pld_ready mirrors flit_ready of the selected VC.
module noc_local_injector
  import noc_local_injector_pkg::*;
#(
  parameter int CHANNELS = NOC_VC_CHANNEL,
  localparam int VC_W = $clog2(CHANNELS)
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst,
  input  logic [NOC_ID_X_WIDTH-1:0] id_x,
  input  logic [NOC_ID_Y_WIDTH-1:0] id_y,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [NOC_ID_X_WIDTH-1:0] req_dst_x,
  input  logic [NOC_ID_Y_WIDTH-1:0] req_dst_y,
  input  logic [LEN_W-1:0]          req_len,
  input  logic                      pld_valid,
  output logic                      pld_ready,
  input  logic [PLD_W-1:0]          pld_data,
  output logic [CHANNELS-1:0]       flit_valid,
  output logic [FLIT_W-1:0]         flit_data,
  input  logic [CHANNELS-1:0]       flit_ready,
  input  logic [CHANNELS-1:0]       vc_ready,
  output logic                      busy,
`ifdef NOC_INJ_PERF_CNT_EN
  output logic [31:0]               perf_pkt_cnt,
  output logic [31:0]               perf_stall_cnt,
`endif
  output noc_inj_state_e            dbg_state
);

  noc_inj_state_e            state_q, state_d;
  logic [NOC_ID_X_WIDTH-1:0] dst_x_q, dst_x_d, src_x_q, src_x_d;
  logic [NOC_ID_Y_WIDTH-1:0] dst_y_q, dst_y_d, src_y_q, src_y_d;
  logic [LEN_W-1:0]          len_q, len_d, rem_q, rem_d;
  logic [VC_W-1:0]           vc_q, vc_d;
  logic [VC_W-1:0]           gnt_idx;
  logic                      gnt_any;
  logic                      req_ready_c;
  noc_head_t                 head_s;
  noc_flit_type_e            ftype;

  noc_local_injector_vc_rr_picker #(.CHANNELS(CHANNELS)) u_rr (
    .clk       (noc_clk),
    .rst       (noc_rst),
    .req       (vc_ready),
    .advance   (state_q == ST_ALLOC),
    .grant_idx (gnt_idx),
    .any_grant (gnt_any)
  );

  always_comb begin
    state_d     = state_q;
    dst_x_d     = dst_x_q;
    dst_y_d     = dst_y_q;
    src_x_d     = src_x_q;
    src_y_d     = src_y_q;
    len_d       = len_q;
    rem_d       = rem_q;
    vc_d        = vc_q;
    req_ready_c = 1'b0;
    pld_ready   = 1'b0;
    flit_valid  = '0;
    flit_data   = '0;
    ftype       = FLIT_BODY;
    head_s      = '{dst_x: dst_x_q, dst_y: dst_y_q, src_x: src_x_q, src_y: src_y_q, len: len_q};

    case (state_q)
      ST_IDLE: begin
        req_ready_c = 1'b1;
        if (req_valid) begin
          dst_x_d = req_dst_x;
          dst_y_d = req_dst_y;
          src_x_d = id_x;
          src_y_d = id_y;
          // Oversized requests are clipped rather than rejected.
          len_d   = (req_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : req_len;
          state_d = ST_ALLOC;
        end
      end
      ST_ALLOC: begin
        if (gnt_any) begin
          vc_d    = gnt_idx;
          state_d = ST_HEAD;
        end
      end
      ST_HEAD: begin
        ftype            = (len_q == '0) ? FLIT_HEAD_TAIL : FLIT_HEAD;
        flit_valid[vc_q] = 1'b1;
        flit_data        = {ftype, head_body(head_s)};
        if (flit_ready[vc_q]) begin
          rem_d   = len_q;
          state_d = (len_q == '0) ? ST_IDLE : ST_BODY;
        end
      end
      ST_BODY: begin
        ftype            = (rem_q == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY;
        flit_valid[vc_q] = pld_valid;
        flit_data        = {ftype, pld_data};
        pld_ready        = flit_ready[vc_q];
        if (pld_valid && flit_ready[vc_q]) begin
          if (rem_q != '0) rem_d = rem_q - LEN_W'(1);
          if (rem_q <= LEN_W'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state_q <= ST_IDLE;
      dst_x_q <= '0;
      dst_y_q <= '0;
      src_x_q <= '0;
      src_y_q <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      dst_x_q <= dst_x_d;
      dst_y_q <= dst_y_d;
      src_x_q <= src_x_d;
      src_y_q <= src_y_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      vc_q    <= vc_d;
    end
  end

  // Held low while reset is asserted even though the state is already IDLE.
  assign req_ready = req_ready_c & ~noc_rst;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

`ifdef NOC_INJ_PERF_CNT_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d, stall_cnt_q, stall_cnt_d;
  logic        tail_xfer;

  always_comb begin
    tail_xfer = ((state_q == ST_HEAD) && (len_q == '0) && flit_ready[vc_q]) ||
                ((state_q == ST_BODY) && (rem_q <= LEN_W'(1)) && pld_valid && flit_ready[vc_q]);
    pkt_cnt_d   = pkt_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (tail_xfer)                    pkt_cnt_d   = pkt_cnt_q + 32'd1;
    if (|(flit_valid & ~flit_ready))  stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_pkt_cnt   = pkt_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_noc_local_injector.sv
// Directed bench for noc_local_injector. Build with +define+NOC_INJ_PERF_CNT_EN
// to also check the performance counters.
module tb_noc_local_injector;
  import noc_local_injector_pkg::*;

  localparam int CH = NOC_VC_CHANNEL;

  logic                      noc_clk, noc_rst;
  logic [NOC_ID_X_WIDTH-1:0] id_x, req_dst_x;
  logic [NOC_ID_Y_WIDTH-1:0] id_y, req_dst_y;
  logic                      req_valid, req_ready;
  logic [LEN_W-1:0]          req_len;
  logic                      pld_valid, pld_ready;
  logic [PLD_W-1:0]          pld_data;
  logic [CH-1:0]             flit_valid, flit_ready, vc_ready;
  logic [FLIT_W-1:0]         flit_data;
  logic                      busy;
  noc_inj_state_e            dbg_state;
`ifdef NOC_INJ_PERF_CNT_EN
  logic [31:0]               perf_pkt_cnt, perf_stall_cnt;
  logic [31:0]               pkt_before, stall_before;
`endif

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [FLIT_W-1:0] exp_q[$];
  int                exp_vc_q[$];
  int                xfer_cyc_q[$];

  noc_local_injector dut (
    .noc_clk        (noc_clk),
    .noc_rst        (noc_rst),
    .id_x           (id_x),
    .id_y           (id_y),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dst_x      (req_dst_x),
    .req_dst_y      (req_dst_y),
    .req_len        (req_len),
    .pld_valid      (pld_valid),
    .pld_ready      (pld_ready),
    .pld_data       (pld_data),
    .flit_valid     (flit_valid),
    .flit_data      (flit_data),
    .flit_ready     (flit_ready),
    .vc_ready       (vc_ready),
    .busy           (busy),
`ifdef NOC_INJ_PERF_CNT_EN
    .perf_pkt_cnt   (perf_pkt_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;
  always @(posedge noc_clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PLD_W-1:0] mk_head(input logic [3:0] dx, input logic [3:0] dy,
                                               input logic [3:0] sx, input logic [3:0] sy,
                                               input logic [4:0] len);
    return {41'd0, dx, dy, sx, sy, len};
  endfunction

  // Scoreboard: every accepted flit is compared against the expected queue.
  always @(negedge noc_clk) begin
    if (!noc_rst && (flit_valid != '0)) begin
      if (exp_vc_q.size() != 0)
        chk("flit_vc_onehot", 64'(flit_valid), 64'd1 << exp_vc_q[0]);
      if ((flit_valid & flit_ready) != '0) begin
        if (exp_q.size() == 0) begin
          chk("flit_unexpected", 64'(exp_q.size()), 64'd1);
        end else begin
          chk("flit_data", flit_data, exp_q.pop_front());
          void'(exp_vc_q.pop_front());
          xfer_cyc_q.push_back(cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_pkt(input int vc, input logic [3:0] dx, input logic [3:0] dy,
                          input logic [4:0] lenf, input logic [PLD_W-1:0] base, input int n_body);
    exp_q.push_back({(lenf == 5'd0) ? 2'b11 : 2'b01, mk_head(dx, dy, id_x, id_y, lenf)});
    exp_vc_q.push_back(vc);
    for (int k = 0; k < n_body; k++) begin
      exp_q.push_back({(k == int'(lenf) - 1) ? 2'b10 : 2'b00, base + PLD_W'(k)});
      exp_vc_q.push_back(vc);
    end
  endtask

  task automatic send_req(input logic [3:0] dx, input logic [3:0] dy, input logic [4:0] len,
                          output int acc);
    req_dst_x = dx;
    req_dst_y = dy;
    req_len   = len;
    req_valid = 1'b1;
    acc       = -1;
    for (int k = 0; k < 50 && acc < 0; k++) begin
      @(negedge noc_clk);
      if (req_ready) acc = cyc;
      @(posedge noc_clk); #1;
    end
    req_valid = 1'b0;
    if (acc < 0) chk("req_accept", 64'(req_ready), 64'd1);
  endtask

  task automatic drive_payload(input int n, input logic [PLD_W-1:0] base, input int gap_at);
    logic hs;
    for (int k = 0; k < n; k++) begin
      if (k == gap_at) begin
        pld_valid = 1'b0;
        repeat (2) begin
          @(negedge noc_clk);
          chk("gap_flit_valid", 64'(flit_valid), 64'd0);
          @(posedge noc_clk); #1;
        end
      end
      pld_valid = 1'b1;
      pld_data  = base + PLD_W'(k);
      hs        = 1'b0;
      for (int t = 0; t < 60 && !hs; t++) begin
        @(negedge noc_clk);
        hs = pld_ready;
        @(posedge noc_clk); #1;
      end
      if (!hs) chk("pld_accept", 64'(pld_ready), 64'd1);
    end
    pld_valid = 1'b0;
  endtask

  task automatic wait_idle(output int idle_cyc);
    idle_cyc = -1;
    for (int t = 0; t < 200 && idle_cyc < 0; t++) begin
      @(negedge noc_clk);
      if (!busy) idle_cyc = cyc;
      @(posedge noc_clk); #1;
    end
    if (idle_cyc < 0) chk("busy_timeout", 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    noc_rst   = 1'b1;
    req_valid = 1'b0;
    pld_valid = 1'b0;
    repeat (2) @(posedge noc_clk);
    #1;
    noc_rst = 1'b0;
    exp_q.delete();
    exp_vc_q.delete();
    #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int acc, ic, n0;
    noc_rst    = 1'b1;
    id_x       = 4'd1;
    id_y       = 4'd2;
    req_valid  = 1'b0;
    req_dst_x  = '0;
    req_dst_y  = '0;
    req_len    = '0;
    pld_valid  = 1'b0;
    pld_data   = '0;
    flit_ready = 4'b1111;
    vc_ready   = 4'b0001;

    // Reset state
    repeat (2) @(posedge noc_clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flit_valid", 64'(flit_valid), 64'd0);
    chk("rst_pld_ready", 64'(pld_ready), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    noc_rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    // 1: len=0 -> single HEAD_TAIL on VC0, head at accept+2, idle the cycle after
    xfer_cyc_q.delete();
    push_pkt(0, 4'd3, 4'd0, 5'd0, '0, 0);
    send_req(4'd3, 4'd0, 5'd0, acc);
    wait_idle(ic);
    chk("t1_xfers", 64'(xfer_cyc_q.size()), 64'd1);
    if (xfer_cyc_q.size() == 1) begin
      chk("t1_head_latency", 64'(xfer_cyc_q[0] - acc), 64'd2);
      chk("t1_idle_after_tail", 64'(ic - xfer_cyc_q[0]), 64'd1);
    end
    chk("t1_req_ready", 64'(req_ready), 64'd1);

    // 2: len=3, payload A,B,C, 4 flits on consecutive cycles
    xfer_cyc_q.delete();
    push_pkt(0, 4'd5, 4'd6, 5'd3, 62'hA, 3);
    send_req(4'd5, 4'd6, 5'd3, acc);
    drive_payload(3, 62'hA, -1);
    wait_idle(ic);
    chk("t2_xfers", 64'(xfer_cyc_q.size()), 64'd4);
    if (xfer_cyc_q.size() == 4)
      chk("t2_span", 64'(xfer_cyc_q[3] - xfer_cyc_q[0]), 64'd3);

    // 3: head stalled 5 cycles on VC1 (other VCs ready, must be ignored)
    vc_ready   = 4'b0010;
    flit_ready = 4'b1101;
`ifdef NOC_INJ_PERF_CNT_EN
    pkt_before   = perf_pkt_cnt;
    stall_before = perf_stall_cnt;
`endif
    push_pkt(1, 4'd2, 4'd1, 5'd1, 62'h33, 1);
    send_req(4'd2, 4'd1, 5'd1, acc);
    n0 = -1;
    for (int t = 0; t < 20 && n0 < 0; t++) begin
      @(negedge noc_clk);
      if (flit_valid != '0) n0 = t;
      else begin @(posedge noc_clk); #1; end
    end
    if (n0 < 0) chk("t3_head_valid", 64'(flit_valid), 64'd2);
    else begin
      for (int s = 0; s < 5; s++) begin
        chk("t3_hold_data", flit_data, {2'b01, mk_head(4'd2, 4'd1, 4'd1, 4'd2, 5'd1)});
        chk("t3_hold_valid", 64'(flit_valid), 64'd2);
        @(posedge noc_clk); #1;
        if (s < 4) @(negedge noc_clk);
      end
    end
    flit_ready = 4'b1111;
    drive_payload(1, 62'h33, -1);
    wait_idle(ic);
`ifdef NOC_INJ_PERF_CNT_EN
    chk("t3_perf_stall", 64'(perf_stall_cnt - stall_before), 64'd5);
    chk("t3_perf_pkt", 64'(perf_pkt_cnt - pkt_before), 64'd1);
`endif

    // 4: round-robin from reset, all VCs ready -> VC0 then VC1
    do_reset();
    vc_ready = 4'b1111;
    push_pkt(0, 4'd7, 4'd7, 5'd0, '0, 0);
    send_req(4'd7, 4'd7, 5'd0, acc);
    wait_idle(ic);
    push_pkt(1, 4'd4, 4'd3, 5'd1, 62'h44, 1);
    send_req(4'd4, 4'd3, 5'd1, acc);
    drive_payload(1, 62'h44, -1);
    wait_idle(ic);
    chk("t4_drained", 64'(exp_q.size()), 64'd0);

    // 5: payload gap mid-body on VC2
    xfer_cyc_q.delete();
    vc_ready = 4'b0100;
    push_pkt(2, 4'd1, 4'd1, 5'd4, 62'h50, 4);
    send_req(4'd1, 4'd1, 5'd4, acc);
    drive_payload(4, 62'h50, 2);
    wait_idle(ic);
    chk("t5_xfers", 64'(xfer_cyc_q.size()), 64'd5);

    // 7: oversize length saturates to MAX_LEN on VC3
    xfer_cyc_q.delete();
    vc_ready = 4'b1000;
    push_pkt(3, 4'd9, 4'd8, 5'd16, 62'h100, 16);
    send_req(4'd9, 4'd8, 5'd20, acc);
    drive_payload(16, 62'h100, -1);
    wait_idle(ic);
    chk("t7_xfers", 64'(xfer_cyc_q.size()), 64'd17);

    // 6: reset mid-packet after 2 body flits of len=8
    vc_ready = 4'b0100;
    push_pkt(2, 4'd6, 4'd5, 5'd8, 62'h60, 2);
    send_req(4'd6, 4'd5, 5'd8, acc);
    drive_payload(2, 62'h60, -1);
    chk("t6_flits_before_rst", 64'(exp_q.size()), 64'd0);
    noc_rst = 1'b1;
    #1;
    chk("t6_flit_valid", 64'(flit_valid), 64'd0);
    chk("t6_flit_data", flit_data, 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_req_ready", 64'(req_ready), 64'd0);
    chk("t6_pld_ready", 64'(pld_ready), 64'd0);
`ifdef NOC_INJ_PERF_CNT_EN
    chk("t6_perf_pkt", 64'(perf_pkt_cnt), 64'd0);
    chk("t6_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
    @(posedge noc_clk); #1;
    noc_rst = 1'b0;
    exp_q.delete();
    exp_vc_q.delete();
    #1;
    chk("t6_req_ready_after", 64'(req_ready), 64'd1);
    vc_ready = 4'b1111;
    push_pkt(0, 4'd2, 4'd2, 5'd0, '0, 0);
    send_req(4'd2, 4'd2, 5'd0, acc);
    wait_idle(ic);

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
